// File: rtl/rwt_adc_capture_ctrl.sv
// ADC burst capture sequencer: gates registered ADC samples into the async FIFO write port.
// States: IDLE wait for start | ARM wait for trigger | CAPTURE count burst samples | GAP inter-burst idle | DONE 1-cycle done
module rwt_adc_capture_ctrl #(
  parameter int DATA_WIDTH = 68,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  adc_clk,
  input  logic                  adc_rst,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [CNT_WIDTH-1:0]  cfg_burst_len,
  input  logic [CNT_WIDTH-1:0]  cfg_burst_count,
  input  logic [CNT_WIDTH-1:0]  cfg_gap_len,
  input  logic                  cfg_use_trigger,
  input  logic                  trigger,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  overflow_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_GAP     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_len_m1;
  logic [CNT_WIDTH-1:0]  r_gap;
  logic                  r_cont;
  logic [CNT_WIDTH-1:0]  r_smp_left;
  logic [CNT_WIDTH-1:0]  r_burst_left;
  logic [CNT_WIDTH-1:0]  r_gap_left;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_last;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_ovf_cnt;

  logic                  w_accept;
  logic                  w_burst_end;
  logic                  w_final;
  logic [CNT_WIDTH-1:0]  w_len_m1;

  // Dropped samples still count toward the burst so timing stays locked to the ADC.
  assign w_accept    = (r_state == ST_CAPTURE) && s_valid && !cfg_stop;
  assign w_burst_end = w_accept && (r_smp_left == '0);
  assign w_final     = w_burst_end && !r_cont && (r_burst_left == '0);
  assign w_len_m1    = (cfg_burst_len == '0) ? '0 : cfg_burst_len - 1'b1;

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      r_state      <= ST_IDLE;
      r_len_m1     <= '0;
      r_gap        <= '0;
      r_cont       <= 1'b0;
      r_smp_left   <= '0;
      r_burst_left <= '0;
      r_gap_left   <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_overflow   <= 1'b0;
      r_ovf_cnt    <= '0;
    end else begin
      r_m_valid <= w_accept && m_ready;
      r_m_last  <= w_burst_end && m_ready;
      if (w_accept && m_ready) r_m_data <= s_data;
      if (w_accept && !m_ready) begin
        r_overflow <= 1'b1;
        if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end

      if (cfg_stop) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (cfg_start) begin
              r_len_m1     <= w_len_m1;
              r_gap        <= cfg_gap_len;
              r_cont       <= (cfg_burst_count == '0);
              r_burst_left <= cfg_burst_count - 1'b1;
              r_smp_left   <= w_len_m1;
              r_overflow   <= 1'b0;
              r_ovf_cnt    <= '0;
              r_state      <= cfg_use_trigger ? ST_ARM : ST_CAPTURE;
            end
          end
          ST_ARM: begin
            if (trigger) r_state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            if (w_accept) begin
              if (r_smp_left == '0) begin
                r_smp_left <= r_len_m1;
                if (w_final) begin
                  r_state <= ST_DONE;
                end else begin
                  if (!r_cont) r_burst_left <= r_burst_left - 1'b1;
                  if (r_gap != '0) begin
                    r_gap_left <= r_gap - 1'b1;
                    r_state    <= ST_GAP;
                  end
                end
              end else begin
                r_smp_left <= r_smp_left - 1'b1;
              end
            end
          end
          ST_GAP: begin
            if (r_gap_left == '0) r_state <= ST_CAPTURE;
            else r_gap_left <= r_gap_left - 1'b1;
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign m_valid        = r_m_valid;
  assign m_data         = r_m_data;
  assign m_last         = r_m_last;
  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign overflow       = r_overflow;
  assign overflow_count = r_ovf_cnt;

endmodule
